// File: rtl/tx_stream_arbiter.sv
// Packet-granular arbiter for the shared 8-bit AXI-Stream transmit path to the MAC.
// Port 0 (ARP) has absolute priority. Ports 1 (TCP) and 2 (UDP) alternate round-robin.
// A grant is held from the first beat to tlast. IFG_CYCLES idle cycles follow each packet.
//
// Ports:
//   aclk, aresetn        clock, asynchronous active-low reset
//   s_tdata_in[3]        source data (0 = ARP, 1 = TCP, 2 = UDP)
//   s_tvalid_in[2:0]     source valid
//   s_tlast_in[2:0]      source end of packet
//   s_tready_out[2:0]    ready back to each source
//   axis_t*_out          stream to the MAC; axis_tready_in is the MAC ready
//   grant_out[2:0]       registered one-hot grant
//   busy_out             high while transferring or in the inter-frame gap
//   pkt_cnt_out[3]       completed packets per port, wraps modulo 2^CNT_W
module tx_stream_arbiter #(
  parameter int unsigned IFG_CYCLES = 12,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [7:0]       s_tdata_in [3],
  input  logic [2:0]       s_tvalid_in,
  input  logic [2:0]       s_tlast_in,
  output logic [2:0]       s_tready_out,
  output logic [7:0]       axis_tdata_out,
  output logic             axis_tvalid_out,
  output logic             axis_tlast_out,
  input  logic             axis_tready_in,
  output logic [2:0]       grant_out,
  output logic             busy_out,
  output logic [CNT_W-1:0] pkt_cnt_out [3]
);

  typedef enum logic [1:0] {StIdle, StXfer, StGap} state_e;

  localparam int unsigned GapW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  // Gap counter counts down from IFG_CYCLES-1 to 0, giving IFG_CYCLES cycles in StGap.
  localparam logic [GapW-1:0] GapLoad = (IFG_CYCLES > 0) ? GapW'(IFG_CYCLES - 1) : '0;

  state_e           state_q, state_d;
  logic [2:0]       grant_q, grant_d;
  // rr_q = 0 prefers port 1, rr_q = 1 prefers port 2.
  logic             rr_q, rr_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic             pkt_done;

  // Combinational pass-through of the granted source while transferring.
  always_comb begin
    axis_tdata_out  = '0;
    axis_tvalid_out = 1'b0;
    axis_tlast_out  = 1'b0;
    s_tready_out    = '0;
    if (state_q == StXfer) begin
      unique case (grant_q)
        3'b001: begin
          axis_tdata_out  = s_tdata_in[0];
          axis_tvalid_out = s_tvalid_in[0];
          axis_tlast_out  = s_tlast_in[0];
          s_tready_out[0] = axis_tready_in;
        end
        3'b010: begin
          axis_tdata_out  = s_tdata_in[1];
          axis_tvalid_out = s_tvalid_in[1];
          axis_tlast_out  = s_tlast_in[1];
          s_tready_out[1] = axis_tready_in;
        end
        3'b100: begin
          axis_tdata_out  = s_tdata_in[2];
          axis_tvalid_out = s_tvalid_in[2];
          axis_tlast_out  = s_tlast_in[2];
          s_tready_out[2] = axis_tready_in;
        end
        default: ;
      endcase
    end
  end

  assign pkt_done = axis_tvalid_out & axis_tready_in & axis_tlast_out;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (|s_tvalid_in) begin
          state_d = StXfer;
          if (s_tvalid_in[0]) begin
            grant_d = 3'b001;
          end else if (s_tvalid_in[1] && (!rr_q || !s_tvalid_in[2])) begin
            grant_d = 3'b010;
          end else begin
            grant_d = 3'b100;
          end
        end
      end
      StXfer: begin
        if (pkt_done) begin
          grant_d = '0;
          gap_d   = GapLoad;
          state_d = (IFG_CYCLES > 0) ? StGap : StIdle;
          if (grant_q[1]) begin
            rr_d = 1'b1;
          end else if (grant_q[2]) begin
            rr_d = 1'b0;
          end
          for (int i = 0; i < 3; i++) begin
            if (grant_q[i]) begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
        end
      end
      StGap: begin
        if (gap_q == '0) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q - GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= StIdle;
      grant_q <= '0;
      rr_q    <= 1'b0;
      gap_q   <= '0;
      cnt_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_out   = grant_q;
  assign busy_out    = (state_q != StIdle);
  assign pkt_cnt_out = cnt_q;

endmodule

// File: tb/tb_tx_stream_arbiter.sv
module tb_tx_stream_arbiter;

  logic        clk;
  logic        rstn;
  logic [7:0]  src_data [3];
  logic [2:0]  src_valid, src_last, src_ready;
  logic [7:0]  m_data;
  logic        m_valid, m_last, m_ready;
  logic [2:0]  gnt;
  logic        busy;
  logic [15:0] cnt [3];

  // Second instance: no gap, narrow counters.
  logic [7:0]  z_data [3];
  logic [2:0]  z_valid, z_last, z_ready;
  logic [7:0]  zm_data;
  logic        zm_valid, zm_last, zm_ready;
  logic [2:0]  z_gnt;
  logic        z_busy;
  logic [3:0]  z_cnt [3];

  int checks = 0;
  int fails  = 0;

  // Traffic engine observations
  int ord [16];
  int gst [16];
  int gend [16];
  int n_done, n_grant, data_bad, rdy_bad;
  bit timeout;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  tx_stream_arbiter #(.IFG_CYCLES(12), .CNT_W(16)) dut (
    .aclk(clk), .aresetn(rstn),
    .s_tdata_in(src_data), .s_tvalid_in(src_valid), .s_tlast_in(src_last),
    .s_tready_out(src_ready),
    .axis_tdata_out(m_data), .axis_tvalid_out(m_valid), .axis_tlast_out(m_last),
    .axis_tready_in(m_ready),
    .grant_out(gnt), .busy_out(busy), .pkt_cnt_out(cnt)
  );

  tx_stream_arbiter #(.IFG_CYCLES(0), .CNT_W(4)) dut_z (
    .aclk(clk), .aresetn(rstn),
    .s_tdata_in(z_data), .s_tvalid_in(z_valid), .s_tlast_in(z_last),
    .s_tready_out(z_ready),
    .axis_tdata_out(zm_data), .axis_tvalid_out(zm_valid), .axis_tlast_out(zm_last),
    .axis_tready_in(zm_ready),
    .grant_out(z_gnt), .busy_out(z_busy), .pkt_cnt_out(z_cnt)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 200 && busy; i++) step();
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL wait_idle: busy=%b required 0 within 200 cycles", busy);
    end
  endtask

  // Drives packets with data {port, beat index}; records grant/last-beat cycles.
  task automatic run_traffic(input int len0, input int len1, input int len2,
                             input logic [2:0] en, input int npkts,
                             input bit rep, input bit toggle);
    int lens [3];
    int idx [3];
    bit done [3];
    logic [2:0] prev_g;
    int g;
    lens = '{len0, len1, len2};
    idx  = '{0, 0, 0};
    done = '{0, 0, 0};
    for (int k = 0; k < 16; k++) begin
      ord[k] = -1; gst[k] = -1; gend[k] = -1;
    end
    n_done = 0; n_grant = 0; data_bad = 0; rdy_bad = 0; timeout = 1'b1;
    prev_g = gnt;
    g = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 3; p++) begin
        src_valid[p] = en[p] && !done[p];
        src_data[p]  = 8'(p * 16 + idx[p]);
        src_last[p]  = (idx[p] == lens[p] - 1);
      end
      m_ready = toggle ? (c % 2 == 1) : 1'b1;
      #1;
      if (gnt !== 3'b000 && prev_g === 3'b000 && n_grant < 16) begin
        ord[n_grant] = gnt[2] ? 2 : (gnt[1] ? 1 : 0);
        gst[n_grant] = c;
        n_grant++;
      end
      prev_g = gnt;
      if (gnt !== 3'b000) begin
        g = gnt[2] ? 2 : (gnt[1] ? 1 : 0);
        for (int q = 0; q < 3; q++) begin
          if (src_ready[q] !== ((q == g) ? m_ready : 1'b0)) rdy_bad++;
        end
      end else if (src_ready !== 3'b000) begin
        rdy_bad++;
      end
      if (m_valid && m_ready) begin
        if (m_data !== 8'(g * 16 + idx[g]) || m_last !== src_last[g]) data_bad++;
        if (m_last) begin
          if (n_done < 16) gend[n_done] = c;
          n_done++;
          idx[g] = 0;
          if (!rep) done[g] = 1'b1;
        end else begin
          idx[g]++;
        end
      end
      step();
      if (n_done == npkts) begin
        timeout = 1'b0;
        break;
      end
    end
    src_valid = '0;
    src_last  = '0;
    m_ready   = 1'b1;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    src_valid = '0; src_last = '0; src_data = '{default: '0};
    z_valid = '0; z_last = '0; z_data = '{default: '0};
    m_ready = 1'b1; zm_ready = 1'b1;
    step(); step();
    checks++;
    if (gnt !== 3'b000 || busy !== 1'b0) begin
      fails++; $display("FAIL reset_state: grant=%b busy=%b required 000/0", gnt, busy);
    end
    checks++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== 8'h00 || src_ready !== 3'b000) begin
      fails++;
      $display("FAIL reset_axis: v=%b l=%b d=%h rdy=%b required all 0",
               m_valid, m_last, m_data, src_ready);
    end
    checks++;
    if (cnt[0] !== 16'd0 || cnt[1] !== 16'd0 || cnt[2] !== 16'd0) begin
      fails++; $display("FAIL reset_cnt: %0d/%0d/%0d required 0/0/0", cnt[0], cnt[1], cnt[2]);
    end
    #3 rstn = 1'b1;
    step();
  endtask

  task automatic test_single_udp;
    run_traffic(1, 1, 60, 3'b100, 1, 1'b0, 1'b0);
    checks++;
    if (timeout !== 1'b0 || gst[0] != 1 || ord[0] != 2) begin
      fails++;
      $display("FAIL udp_grant: timeout=%b grant_cycle=%0d port=%0d required 0/1/2",
               timeout, gst[0], ord[0]);
    end
    checks++;
    if (data_bad != 0 || rdy_bad != 0) begin
      fails++; $display("FAIL udp_data: bad_beats=%0d bad_ready=%0d required 0/0",
                        data_bad, rdy_bad);
    end
    checks++;
    if (cnt[2] !== 16'd1) begin
      fails++; $display("FAIL udp_cnt: got %0d required 1", cnt[2]);
    end
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (busy !== 1'b1 || gnt !== 3'b000) begin
        fails++; $display("FAIL udp_gap_busy: cycle %0d busy=%b grant=%b required 1/000",
                          k, busy, gnt);
      end
      step();
    end
    checks++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL udp_gap_end: busy=%b required 0", busy);
    end
  endtask

  task automatic test_arp_priority;
    wait_idle();
    run_traffic(3, 4, 5, 3'b111, 3, 1'b0, 1'b0);
    checks++;
    if (timeout !== 1'b0 || ord[0] != 0 || ord[1] != 1 || ord[2] != 2) begin
      fails++; $display("FAIL arp_order: got %0d,%0d,%0d required 0,1,2",
                        ord[0], ord[1], ord[2]);
    end
    checks++;
    if (gst[1] - (gend[0] + 1) != 13 || gst[2] - (gend[1] + 1) != 13) begin
      fails++; $display("FAIL arp_spacing: got %0d,%0d required 13,13",
                        gst[1] - (gend[0] + 1), gst[2] - (gend[1] + 1));
    end
    checks++;
    if (data_bad != 0 || rdy_bad != 0) begin
      fails++; $display("FAIL arp_data: bad_beats=%0d bad_ready=%0d required 0/0",
                        data_bad, rdy_bad);
    end
    checks++;
    if (cnt[0] !== 16'd1 || cnt[1] !== 16'd1 || cnt[2] !== 16'd2) begin
      fails++; $display("FAIL arp_cnt: %0d/%0d/%0d required 1/1/2", cnt[0], cnt[1], cnt[2]);
    end
  endtask

  task automatic test_round_robin;
    wait_idle();
    run_traffic(1, 10, 10, 3'b110, 4, 1'b1, 1'b0);
    checks++;
    if (timeout !== 1'b0 || ord[0] != 1 || ord[1] != 2 || ord[2] != 1 || ord[3] != 2) begin
      fails++; $display("FAIL rr_order: got %0d,%0d,%0d,%0d required 1,2,1,2",
                        ord[0], ord[1], ord[2], ord[3]);
    end
    checks++;
    if (cnt[1] !== 16'd3 || cnt[2] !== 16'd4) begin
      fails++; $display("FAIL rr_cnt: tcp=%0d udp=%0d required 3/4", cnt[1], cnt[2]);
    end
    checks++;
    if (data_bad != 0 || gst[1] - (gend[0] + 1) != 13) begin
      fails++; $display("FAIL rr_data: bad_beats=%0d spacing=%0d required 0/13",
                        data_bad, gst[1] - (gend[0] + 1));
    end
  endtask

  task automatic test_stall;
    wait_idle();
    m_ready = 1'b1;
    src_valid[2] = 1'b1; src_data[2] = 8'hA0; src_last[2] = 1'b0;
    step();
    checks++;
    if (gnt !== 3'b100) begin
      fails++; $display("FAIL stall_grant: got %b required 100", gnt);
    end
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin
        src_valid[2] = 1'b0;
        for (int k = 0; k < 5; k++) begin
          #1;
          checks++;
          if (m_valid !== 1'b0 || gnt !== 3'b100) begin
            fails++; $display("FAIL stall_hold: cycle %0d valid=%b grant=%b required 0/100",
                              k, m_valid, gnt);
          end
          step();
        end
      end
      src_valid[2] = 1'b1; src_data[2] = 8'(8'hA0 + i); src_last[2] = (i == 5);
      #1;
      checks++;
      if (m_valid !== 1'b1 || m_data !== 8'(8'hA0 + i) || src_ready[2] !== 1'b1) begin
        fails++; $display("FAIL stall_beat: beat %0d valid=%b data=%h rdy=%b required 1/%h/1",
                          i, m_valid, m_data, src_ready[2], 8'(8'hA0 + i));
      end
      step();
    end
    src_valid = '0; src_last = '0;
    checks++;
    if (cnt[2] !== 16'd5 || busy !== 1'b1 || gnt !== 3'b000) begin
      fails++; $display("FAIL stall_done: cnt=%0d busy=%b grant=%b required 5/1/000",
                        cnt[2], busy, gnt);
    end
  endtask

  task automatic test_backpressure;
    wait_idle();
    run_traffic(1, 8, 1, 3'b010, 1, 1'b0, 1'b1);
    checks++;
    if (timeout !== 1'b0 || data_bad != 0 || rdy_bad != 0) begin
      fails++; $display("FAIL bp_data: timeout=%b bad_beats=%0d bad_ready=%0d required 0/0/0",
                        timeout, data_bad, rdy_bad);
    end
    checks++;
    if (cnt[1] !== 16'd4) begin
      fails++; $display("FAIL bp_cnt: got %0d required 4", cnt[1]);
    end
  endtask

  task automatic test_ifg_zero;
    zm_ready = 1'b1;
    z_valid[0] = 1'b1; z_last[0] = 1'b1; z_data[0] = 8'h5A;
    step();
    for (int p = 1; p <= 16; p++) begin
      checks++;
      if (z_gnt !== 3'b001 || zm_valid !== 1'b1 || zm_last !== 1'b1 || zm_data !== 8'h5A) begin
        fails++; $display("FAIL ifg0_xfer: pkt %0d grant=%b v=%b l=%b d=%h required 001/1/1/5a",
                          p, z_gnt, zm_valid, zm_last, zm_data);
      end
      step();
      checks++;
      if (z_gnt !== 3'b000 || z_busy !== 1'b0 || z_cnt[0] !== 4'(p)) begin
        fails++; $display("FAIL ifg0_idle: pkt %0d grant=%b busy=%b cnt=%0d required 000/0/%0d",
                          p, z_gnt, z_busy, z_cnt[0], p % 16);
      end
      if (p == 16) z_valid[0] = 1'b0;
      step();
    end
    checks++;
    if (z_gnt !== 3'b000 || z_cnt[0] !== 4'd0) begin
      fails++; $display("FAIL ifg0_stop: grant=%b cnt=%0d required 000/0", z_gnt, z_cnt[0]);
    end
  endtask

  task automatic test_async_reset;
    wait_idle();
    m_ready = 1'b1;
    src_valid[2] = 1'b1; src_data[2] = 8'h55; src_last[2] = 1'b0;
    step(); step(); step();
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (gnt !== 3'b000 || busy !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0 ||
        m_data !== 8'h00 || src_ready !== 3'b000) begin
      fails++; $display("FAIL areset_outputs: grant=%b busy=%b v=%b l=%b d=%h rdy=%b required 0",
                        gnt, busy, m_valid, m_last, m_data, src_ready);
    end
    checks++;
    if (cnt[0] !== 16'd0 || cnt[1] !== 16'd0 || cnt[2] !== 16'd0) begin
      fails++; $display("FAIL areset_cnt: %0d/%0d/%0d required 0/0/0", cnt[0], cnt[1], cnt[2]);
    end
    #1 rstn = 1'b1;
    step();
    checks++;
    if (gnt !== 3'b100) begin
      fails++; $display("FAIL areset_regrant: got %b required 100", gnt);
    end
    src_data[2] = 8'h77; src_last[2] = 1'b1;
    #1;
    checks++;
    if (m_data !== 8'h77 || m_last !== 1'b1 || m_valid !== 1'b1) begin
      fails++; $display("FAIL areset_beat: d=%h l=%b v=%b required 77/1/1",
                        m_data, m_last, m_valid);
    end
    step();
    src_valid = '0; src_last = '0;
    checks++;
    if (cnt[2] !== 16'd1) begin
      fails++; $display("FAIL areset_cnt_after: got %0d required 1", cnt[2]);
    end
    // Before reset the last completed packet was TCP; a reset rr picks TCP over UDP.
    wait_idle();
    src_valid = 3'b110; src_last = 3'b110; src_data[1] = 8'h11; src_data[2] = 8'h22;
    step();
    checks++;
    if (gnt !== 3'b010) begin
      fails++; $display("FAIL areset_rr: grant=%b required 010", gnt);
    end
    src_valid[2] = 1'b0;
    step();
    src_valid = '0; src_last = '0;
    checks++;
    if (cnt[1] !== 16'd1 || cnt[2] !== 16'd1) begin
      fails++; $display("FAIL areset_rr_cnt: tcp=%0d udp=%0d required 1/1", cnt[1], cnt[2]);
    end
  endtask

  initial begin
    test_reset();
    test_single_udp();
    test_arp_priority();
    test_round_robin();
    test_stall();
    test_backpressure();
    test_ifg_zero();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/tx_stream_arbiter.md
# tx_stream_arbiter

Packet-granular arbiter sharing the single 8-bit AXI-Stream transmit path toward the MAC between three sources: the ARP reply generator (port 0), the TCP control-segment generator (port 1) and the UDP/IP packet generator (port 2). ARP replies always win. TCP and UDP alternate round-robin. A grant is held from the first beat to `tlast`, and a programmable inter-frame gap is inserted between packets. Per-port packet counters and grant status are exported for debug.

## Interface
- `IFG_CYCLES`, default 12: idle cycles inserted after each packet's last beat; 0 means no gap.
- `CNT_W`, default 16: width of each per-port packet counter.
- `aclk`, input, 1: single clock for the block.
- `aresetn`, input, 1: reset, asynchronous and active-low.
- `s_tdata_in[0..2]`, input, 3x8: source data for ARP, TCP and UDP.
- `s_tvalid_in[0..2]`, input, 3x1: source valid.
- `s_tlast_in[0..2]`, input, 3x1: source end of packet.
- `s_tready_out[0..2]`, output, 3x1: ready back to each source.
- `axis_tdata_out`, output, 8: data to the MAC.
- `axis_tvalid_out`, output, 1: valid to the MAC.
- `axis_tlast_out`, output, 1: end of packet to the MAC.
- `axis_tready_in`, input, 1: MAC ready.
- `grant_out`, output, 3: one-hot grant, registered.
- `busy_out`, output, 1: high in XFER or GAP.
- `pkt_cnt_out[0..2]`, output, 3xCNT_W: completed packets per port; wraps modulo 2^CNT_W.

## Operation
- State machine:
  - IDLE -> XFER when any `s_tvalid_in` is high.
  - XFER -> GAP when a beat completes with `tlast` and `IFG_CYCLES>0`.
  - XFER -> IDLE when a beat completes with `tlast` and `IFG_CYCLES==0`.
  - GAP -> IDLE after exactly `IFG_CYCLES` cycles.
- Arbitration runs only in IDLE:
  - Port 0 is chosen if its valid is high.
  - Otherwise the choice is between ports 1 and 2 using the round-robin pointer `rr`, which starts at 1 after reset.
  - If only one of ports 1 and 2 is valid, that one is chosen.
- On completion of a port 1 packet, `rr` moves to 2. On completion of a port 2 packet, `rr` moves to 1. Port 0 packets leave `rr` unchanged.
- In XFER the output is a combinational pass-through of the granted port:
  - `axis_tdata_out`, `axis_tvalid_out` and `axis_tlast_out` follow the granted source.
  - The granted port's `s_tready_out` equals `axis_tready_in`.
  - Ungranted ports see `s_tready_out=0`.
- Outside XFER: `axis_tvalid_out=0`, `axis_tlast_out=0`, `axis_tdata_out=0`, and every `s_tready_out=0`.
- A beat completes when `axis_tvalid_out && axis_tready_in`.
- A source dropping `tvalid` mid-packet stalls the output. The grant is held; there is no timeout and no pre-emption.
- `pkt_cnt_out[g]` increments on the completing beat of each packet on port g.
- `grant_out` is set on entry to XFER and cleared on leaving XFER.

## Timing
- Reset values, applied asynchronously while `aresetn=0`:
  - state IDLE, `grant_out=0`, `busy_out=0`, `rr=1`, all counters 0.
  - All AXIS outputs and all `s_tready_out` are 0.
  - Reset in the middle of a packet truncates it; no `tlast` is emitted.
- Arbitration latency is one cycle. A valid seen at edge N in IDLE gives a grant and XFER at edge N; the first beat can transfer in cycle N+1.
- Data path latency is zero: combinational from source to MAC, with no buffering.
- Packet spacing is exactly `IFG_CYCLES+1` cycles from the `tlast` beat edge to the edge where the next grant is taken. `busy_out` stays high through GAP.
- Requests arriving during XFER or GAP are not sampled until IDLE. Sources must hold `tvalid` (AXIS rule).
- Simultaneous requests on all three ports resolve as 0, then `rr`, then the other.
- A single-beat packet (`tlast` on the first beat) is legal and counts as one packet.

## Test plan
- **Single UDP packet of 60 beats.** Required: `grant_out=100` one cycle after valid; 60 beats pass unchanged; `pkt_cnt_out[2]=1`; `busy_out` stays high for 12 cycles after `tlast`.
- **ARP priority.** ARP, TCP and UDP valid in the same cycle. Required order: ARP, TCP, UDP. Gaps between packets are exactly 12 idle cycles.
- **Round-robin.** TCP and UDP continuously valid with 10-beat packets. Required: the sequence alternates TCP, UDP, TCP, UDP, and counters read 2/2 after 4 packets.
- **Backpressure and stall.**
  - `axis_tready_in` toggles every cycle: the granted `s_tready_out` mirrors it and there is no data loss.
  - Source `tvalid` low for 5 cycles mid-packet: `axis_tvalid_out=0` for those 5 cycles and the grant is unchanged.
- **IFG_CYCLES=0.** Back-to-back single-beat ARP packets. Required: IDLE to XFER each 2 cycles; `pkt_cnt_out[0]` reaches 0xFFFF, then wraps to 0 (use `CNT_W=16` with a preloaded force, or `CNT_W=4` wrapping after 16).
- **Async reset mid-packet.** `aresetn` low between clock edges. Required: all outputs go to 0 immediately; after release a new UDP packet wins normally and `rr` is 1.
